// File: rtl/mul_float_arbiter.sv
// Round-robin front end that shares one mul_float pipeline among P_REQ_N requesters.
// An in-order tag FIFO remembers who issued each operation so results are routed back.
module mul_float_arbiter #(
  parameter int P_REQ_N     = 4,
  parameter int P_REQ_W     = 2,
  parameter int P_TAG_DEPTH = 8,
  parameter int P_TAG_DW    = 3
) (
  input  logic                   iCLOCK,
  input  logic                   inRESET,
  input  logic                   iRESET_SYNC,
  input  logic [P_REQ_N-1:0]     iREQ_VALID,
  output logic [P_REQ_N-1:0]     oREQ_BUSY,
  input  logic [32*P_REQ_N-1:0]  iREQ_A,
  input  logic [32*P_REQ_N-1:0]  iREQ_B,
  output logic [P_REQ_N-1:0]     oRSP_VALID,
  input  logic [P_REQ_N-1:0]     iRSP_BUSY,
  output logic [31:0]            oRSP_DATA,
  output logic                   oMUL_REQ,
  input  logic                   iMUL_BUSY,
  output logic [31:0]            oMUL_A,
  output logic [31:0]            oMUL_B,
  input  logic                   iMUL_VALID,
  output logic                   oMUL_BUSY,
  input  logic [31:0]            iMUL_DATA,
  output logic [P_TAG_DW:0]      oINFLIGHT,
  output logic                   oERR
);

  localparam logic [P_REQ_W:0]   LP_N     = (P_REQ_W+1)'(P_REQ_N);
  localparam logic [P_REQ_W-1:0] LP_LAST  = P_REQ_W'(P_REQ_N - 1);
  localparam logic [P_TAG_DW:0]  LP_DEPTH = (P_TAG_DW+1)'(P_TAG_DEPTH);

  logic                in_reset;
  logic [P_REQ_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [P_REQ_W-1:0]  grant_idx;
  logic                grant_found;
  logic [P_REQ_W:0]    scan_idx;
  logic [P_REQ_W-1:0]  tag_mem_q [P_TAG_DEPTH];
  logic [P_TAG_DW-1:0] wr_ptr_q, rd_ptr_q;
  logic [P_TAG_DW:0]   count_q, count_d;
  logic                err_q;
  logic [P_REQ_W-1:0]  head_tag;
  logic                tag_full, tag_empty;
  logic                accept, pop, orphan;

  assign in_reset = !inRESET || iRESET_SYNC;

  // Scan upward from the round-robin pointer, wrapping modulo P_REQ_N.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < P_REQ_N; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (P_REQ_W+1)'(k);
      if (scan_idx >= LP_N) scan_idx = scan_idx - LP_N;
      if (!grant_found && iREQ_VALID[scan_idx[P_REQ_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[P_REQ_W-1:0];
      end
    end
  end

  assign tag_full  = (count_q == LP_DEPTH);
  assign tag_empty = (count_q == '0);
  assign head_tag  = tag_mem_q[rd_ptr_q];

  assign oMUL_REQ = (|iREQ_VALID) && !tag_full && !in_reset;
  assign oMUL_A   = grant_found ? iREQ_A[grant_idx*32 +: 32] : 32'h0;
  assign oMUL_B   = grant_found ? iREQ_B[grant_idx*32 +: 32] : 32'h0;
  assign accept   = oMUL_REQ && !iMUL_BUSY;

  always_comb begin
    oREQ_BUSY = '1;
    if (accept) oREQ_BUSY[grant_idx] = 1'b0;
  end

  // Strictly in-order return: a busy head requester stalls every later result.
  assign oMUL_BUSY = !tag_empty && iRSP_BUSY[head_tag] && !in_reset;
  assign oRSP_DATA = iMUL_DATA;

  always_comb begin
    oRSP_VALID = '0;
    if (iMUL_VALID && !tag_empty && !in_reset) oRSP_VALID[head_tag] = 1'b1;
  end

  assign pop    = iMUL_VALID && !oMUL_BUSY && !tag_empty;
  assign orphan = iMUL_VALID && tag_empty;

  assign rr_ptr_d = !accept ? rr_ptr_q :
                    (grant_idx == LP_LAST) ? '0 : grant_idx + 1'b1;
  assign count_d  = count_q + (P_TAG_DW+1)'(accept) - (P_TAG_DW+1)'(pop);

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else if (iRESET_SYNC) begin
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_q + P_TAG_DW'(accept);
      rd_ptr_q <= rd_ptr_q + P_TAG_DW'(pop);
      count_q  <= count_d;
      err_q    <= err_q || orphan;
    end
  end

  // NOTE: tag storage is not reset; entries are only read between matching push and pop.
  always_ff @(posedge iCLOCK) begin
    if (accept) tag_mem_q[wr_ptr_q] <= grant_idx;
  end

  assign oINFLIGHT = count_q;
  assign oERR      = err_q;

endmodule

// File: tb/tb_mul_float_arbiter.sv
// Bench for mul_float_arbiter: queue-based reference model, mul_float stub (oDATA=A^B,
// configurable latency), directed vectors and a randomized soak.
module tb_mul_float_arbiter;

  logic         clk = 1'b0;
  logic         rst_n, rst_sync;
  logic [3:0]   req_valid, req_busy, rsp_valid, rsp_busy;
  logic [127:0] req_a, req_b;
  logic [31:0]  rsp_data, mul_a, mul_b, mul_data;
  logic         mul_req, mul_busy_in, mul_valid, mul_busy_out;
  logic [3:0]   inflight;
  logic         err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct { int req; logic [31:0] data; } tag_t;
  typedef struct { logic [31:0] data; int ready; } stub_t;
  typedef struct { logic [3:0] valid; logic exp_req; logic [3:0] exp_busy; } vec_t;

  int    m_ptr = 0;
  tag_t  m_tags[$];
  bit    m_err = 0;
  stub_t stub_q[$];
  int    stub_lat = 3;
  int    last_acc, last_rsp;
  logic [31:0] last_rsp_data;

  mul_float_arbiter dut (
    .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(rst_sync),
    .iREQ_VALID(req_valid), .oREQ_BUSY(req_busy), .iREQ_A(req_a), .iREQ_B(req_b),
    .oRSP_VALID(rsp_valid), .iRSP_BUSY(rsp_busy), .oRSP_DATA(rsp_data),
    .oMUL_REQ(mul_req), .iMUL_BUSY(mul_busy_in), .oMUL_A(mul_a), .oMUL_B(mul_b),
    .iMUL_VALID(mul_valid), .oMUL_BUSY(mul_busy_out), .iMUL_DATA(mul_data),
    .oINFLIGHT(inflight), .oERR(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic stub_drive();
    mul_valid = (stub_q.size() > 0) && (stub_q[0].ready <= cyc);
    mul_data  = mul_valid ? stub_q[0].data : 32'h0;
  endtask

  // One clock: compare DUT outputs with the model at negedge, then advance model and stub.
  task automatic step();
    int g;
    bit rst, e_req, e_mb, acc_m, pop_m;
    logic [3:0]  e_busy, e_rsp;
    logic [31:0] e_a, e_b;
    @(negedge clk);
    rst = rst_sync;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    e_req  = !rst && (g >= 0) && (m_tags.size() < 8);
    e_busy = 4'hF;
    if (e_req && !mul_busy_in) e_busy[g] = 1'b0;
    e_a = (g >= 0) ? req_a[g*32 +: 32] : 32'h0;
    e_b = (g >= 0) ? req_b[g*32 +: 32] : 32'h0;
    e_rsp = 4'h0;
    e_mb  = 1'b0;
    if (!rst && m_tags.size() > 0) begin
      e_mb = rsp_busy[m_tags[0].req];
      if (mul_valid) e_rsp[m_tags[0].req] = 1'b1;
    end
    check("mul_req", mul_req, e_req);
    check("req_busy", req_busy, e_busy);
    check("mul_a", mul_a, e_a);
    check("mul_b", mul_b, e_b);
    check("rsp_valid", rsp_valid, e_rsp);
    if (!rst) check("mul_busy", mul_busy_out, e_mb);
    if (e_rsp != 0) check("rsp_data", rsp_data, m_tags[0].data);
    check("inflight", inflight, m_tags.size());
    check("err", err, m_err);

    last_acc = -1;
    last_rsp = -1;
    for (int i = 0; i < 4; i++) if (!req_busy[i]) last_acc = i;
    if (mul_valid && !mul_busy_out)
      for (int i = 0; i < 4; i++) if (rsp_valid[i]) last_rsp = i;
    last_rsp_data = rsp_data;

    if (rst) begin
      m_ptr = 0;
      m_tags.delete();
      m_err = 0;
      stub_q.delete();
    end else begin
      acc_m = e_req && !mul_busy_in;
      pop_m = mul_valid && !e_mb && (m_tags.size() > 0);
      if (mul_valid && m_tags.size() == 0) m_err = 1;
      if (pop_m) void'(m_tags.pop_front());
      if (acc_m) begin
        m_tags.push_back('{req: g, data: e_a ^ e_b});
        m_ptr = (g + 1) % 4;
      end
      if (mul_valid && !mul_busy_out && stub_q.size() > 0) void'(stub_q.pop_front());
      if (mul_req && !mul_busy_in) stub_q.push_back('{data: mul_a ^ mul_b, ready: cyc + stub_lat});
    end
    @(posedge clk);
    #1;
    cyc++;
    stub_drive();
    #1;
  endtask

  task automatic sync_reset();
    rst_sync  = 1'b1;
    req_valid = 4'h0;
    step();
    rst_sync  = 1'b0;
  endtask

  vec_t vecs[8];
  bit   pend[4];
  int   n, nacc, nrsp;
  int   grants[5], rsps[5];
  logic [31:0] rdat[5];

  initial begin
    vecs[0] = '{4'b0001, 1'b1, 4'b1110};
    vecs[1] = '{4'b1111, 1'b1, 4'b1101};
    vecs[2] = '{4'b0011, 1'b1, 4'b1110};
    vecs[3] = '{4'b1000, 1'b1, 4'b0111};
    vecs[4] = '{4'b0000, 1'b0, 4'b1111};
    vecs[5] = '{4'b0110, 1'b1, 4'b1101};
    vecs[6] = '{4'b0100, 1'b1, 4'b1011};
    vecs[7] = '{4'b0101, 1'b1, 4'b1110};

    rst_n = 1'b0; rst_sync = 1'b0;
    req_valid = 4'hF; rsp_busy = 4'h0; mul_busy_in = 1'b0;
    mul_valid = 1'b0; mul_data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'h1000 + i;
      req_b[i*32 +: 32] = 32'h2000 + i;
    end
    #12;
    check("rst_mul_req", mul_req, 1'b0);
    check("rst_req_busy", req_busy, 4'hF);
    check("rst_rsp_valid", rsp_valid, 4'h0);
    check("rst_inflight", inflight, 0);
    check("rst_err", err, 1'b0);
    req_valid = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;

    // Arbitration table: pointer evolves 0,1,2,1,0,0,2,3 -> 1
    for (int k = 0; k < 8; k++) begin
      req_valid = vecs[k].valid;
      #1;
      check($sformatf("vec%0d_req", k), mul_req, vecs[k].exp_req);
      check($sformatf("vec%0d_busy", k), req_busy, vecs[k].exp_busy);
      step();
    end
    req_valid = 4'h0;
    for (int k = 0; k < 10; k++) step();

    // Single request from requester 0, 3-cycle stub
    sync_reset();
    req_valid = 4'b0001;
    req_a[31:0] = 32'h82200000;
    req_b[31:0] = 32'h00000001;
    #1;
    check("t1_req", mul_req, 1'b1);
    check("t1_busy0", req_busy[0], 1'b0);
    step();
    req_valid = 4'h0;
    check("t1_inflight1", inflight, 1);
    n = 0;
    while (!mul_valid && n < 10) begin step(); n++; end
    check("t1_latency", n, 2);
    check("t1_rsp_valid", rsp_valid, 4'b0001);
    check("t1_rsp_data", rsp_data, 32'h82200001);
    step();
    check("t1_inflight0", inflight, 0);

    // All four requesters continuously valid
    sync_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = i;
      req_b[i*32 +: 32] = 32'h100;
    end
    req_valid = 4'hF;
    nacc = 0; nrsp = 0;
    for (int k = 0; k < 40 && nrsp < 5; k++) begin
      step();
      if (last_acc >= 0 && nacc < 5) begin grants[nacc] = last_acc; nacc++; end
      if (last_rsp >= 0 && nrsp < 5) begin rsps[nrsp] = last_rsp; rdat[nrsp] = last_rsp_data; nrsp++; end
      if (nacc == 5) req_valid = 4'h0;
    end
    check("t2_nrsp", nrsp, 5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_grant%0d", k), grants[k], k % 4);
      check($sformatf("t2_rsp%0d", k), rsps[k], k % 4);
      check($sformatf("t2_data%0d", k), rdat[k], 32'h100 + (k % 4));
    end
    for (int k = 0; k < 6; k++) step();

    // Stall while requester 2 is granted
    sync_reset();
    req_a[64 +: 32] = 32'hDEAD0002;
    req_valid = 4'b0100;
    mul_busy_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_stall_a", mul_a, 32'hDEAD0002);
      check("t3_stall_busy", req_busy, 4'hF);
      step();
    end
    mul_busy_in = 1'b0;
    #1;
    check("t3_accept_busy", req_busy, 4'b1011);
    step();
    check("t3_acc", last_acc, 2);
    req_valid = 4'b1101;
    #1;
    check("t3_next_grant", req_busy, 4'b0111);
    step();
    req_valid = 4'h0;
    for (int k = 0; k < 8; k++) step();

    // Fill the tag FIFO with a 20-cycle stub
    sync_reset();
    stub_lat = 20;
    req_valid = 4'b0001;
    nacc = 0;
    for (int k = 0; k < 12 && nacc < 8; k++) begin
      step();
      if (last_acc == 0) nacc++;
    end
    check("t4_nacc", nacc, 8);
    check("t4_inflight", inflight, 8);
    check("t4_busy_full", req_busy[0], 1'b1);
    check("t4_req_full", mul_req, 1'b0);
    n = 0;
    while (!mul_valid && n < 30) begin step(); n++; end
    check("t4_result_seen", mul_valid, 1'b1);
    check("t4_busy_on_pop", req_busy[0], 1'b1);
    step();
    check("t4_popped", last_rsp, 0);
    check("t4_reopen", req_busy[0], 1'b0);
    step();
    req_valid = 4'h0;
    for (int k = 0; k < 300 && inflight != 0; k++) step();
    check("t4_drain", inflight, 0);
    stub_lat = 3;

    // Head-of-line hold for requester 1
    sync_reset();
    req_a[32 +: 32] = 32'hA5A50000;
    req_b[32 +: 32] = 32'h0000005A;
    req_valid = 4'b0010;
    step();
    req_valid = 4'h0;
    rsp_busy = 4'b0010;
    n = 0;
    while (!mul_valid && n < 10) begin step(); n++; end
    for (int k = 0; k < 4; k++) begin
      check("t5_hold_busy", mul_busy_out, 1'b1);
      check("t5_hold_valid", rsp_valid, 4'b0010);
      step();
    end
    rsp_busy = 4'h0;
    #1;
    check("t5_release", mul_busy_out, 1'b0);
    step();
    check("t5_rsp", last_rsp, 1);
    check("t5_data", last_rsp_data, 32'hA5A5005A);

    // Orphan result, then sync reset with an operation in flight
    sync_reset();
    stub_q.push_back('{data: 32'h12345678, ready: cyc});
    stub_drive();
    #1;
    check("t6_orphan_valid", rsp_valid, 4'h0);
    check("t6_orphan_busy", mul_busy_out, 1'b0);
    step();
    check("t6_err", err, 1'b1);
    req_valid = 4'b1000;
    step();
    req_valid = 4'h0;
    check("t6_inflight1", inflight, 1);
    check("t6_err_sticky", err, 1'b1);
    sync_reset();
    check("t6_err_clr", err, 1'b0);
    check("t6_inflight_clr", inflight, 0);

    // Randomized soak against the model
    for (int i = 0; i < 4; i++) pend[i] = 0;
    for (int k = 0; k < 1500; k++) begin
      if (k % 250 == 0 && stub_q.size() == 0) stub_lat = $urandom_range(1, 12);
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i] = 1;
          req_a[i*32 +: 32] = $urandom;
          req_b[i*32 +: 32] = $urandom;
        end
        req_valid[i] = pend[i];
        rsp_busy[i]  = ($urandom % 4 == 0);
      end
      mul_busy_in = ($urandom % 4 == 0);
      rst_sync    = ($urandom % 400 == 0);
      step();
      rst_sync = 1'b0;
      if (last_acc >= 0) pend[last_acc] = 0;
    end
    req_valid = 4'h0; rsp_busy = 4'h0; mul_busy_in = 1'b0;
    for (int k = 0; k < 100 && inflight != 0; k++) step();
    check("soak_drain", inflight, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_float_arbiter.md
Name: mul_float_arbiter

Overview:
- Shares one mul_float pipeline among P_REQ_N requesters using round-robin arbitration.
- Tags each accepted operation with its requester index in an in-order tag FIFO.
- Routes each mul_float result back to the requester that issued it.
- Sits between the core's FP issue ports and the single mul_float instance, using the same REQ/BUSY and VALID/BUSY handshakes on both sides.

Parameters:
P_REQ_N, 4, number of requesters (2..8)
P_REQ_W, 2, index width, equal to clog2(P_REQ_N)
P_TAG_DEPTH, 8, tag FIFO depth, which bounds the number of operations in flight (power of 2)
P_TAG_DW, 3, equal to clog2(P_TAG_DEPTH)

Ports:
iCLOCK  in  1  clock
inRESET  in  1  asynchronous active-low reset
iRESET_SYNC  in  1  synchronous reset, active-high
iREQ_VALID  in  P_REQ_N  per-requester operation request
oREQ_BUSY  out  P_REQ_N  per-requester stall; operation is accepted when iREQ_VALID[i] && !oREQ_BUSY[i]
iREQ_A  in  32*P_REQ_N  operand A, slice i belongs to requester i
iREQ_B  in  32*P_REQ_N  operand B, slice i
oRSP_VALID  out  P_REQ_N  result valid for requester i (one-hot or zero)
iRSP_BUSY  in  P_REQ_N  requester i cannot take its result
oRSP_DATA  out  32  result data, shared by all requesters
oMUL_REQ  out  1  to mul_float iDATA_REQ
iMUL_BUSY  in  1  from mul_float oDATA_BUSY
oMUL_A  out  32  to mul_float iDATA_A
oMUL_B  out  32  to mul_float iDATA_B
iMUL_VALID  in  1  from mul_float oDATA_VALID
oMUL_BUSY  out  1  to mul_float iDATA_BUSY
iMUL_DATA  in  32  from mul_float oDATA
oINFLIGHT  out  P_TAG_DW+1  count of accepted operations whose results are not yet delivered
oERR  out  1  sticky flag: a result arrived with no tag outstanding

Behaviour:
- Reset values (inRESET low asynchronously, or iRESET_SYNC high at a clock edge): round-robin pointer=0, tag FIFO empty, oINFLIGHT=0, oERR=0.
- During reset, all oRSP_VALID=0, oMUL_REQ=0, and oREQ_BUSY is all ones.
- Arbitration is combinational. The grant is the first i with iREQ_VALID[i] set, searching upward from the pointer and wrapping modulo P_REQ_N.
- oMUL_REQ = any iREQ_VALID && !tag_full && !reset. oMUL_A/oMUL_B = operand slices of the granted requester; all zero when nothing is granted.
- oREQ_BUSY[i] = !(grant[i] && oMUL_REQ && !iMUL_BUSY). Non-granted requesters see busy=1.
- Accept = oMUL_REQ && !iMUL_BUSY. On accept, the granted index is pushed into the tag FIFO and the pointer becomes (grant+1) mod P_REQ_N.
- The pointer holds when there is no accept, so a stalled grant stays stable while iMUL_BUSY is high.
- The requester must hold operands stable until accepted. There is zero added latency on the request path; oMUL_* is combinational from iREQ_* and state.
- Response routing: head tag h. oRSP_DATA = iMUL_DATA. oRSP_VALID[h] = iMUL_VALID && !tag_empty; all other bits are 0.
- oMUL_BUSY = !tag_empty && iRSP_BUSY[h]. Results are therefore strictly in order, and one busy requester blocks the rest (head-of-line blocking by design).
- Pop = iMUL_VALID && !oMUL_BUSY && !tag_empty.
- Orphan result: iMUL_VALID while tag_empty → oMUL_BUSY=0, no oRSP_VALID, result dropped, oERR set until reset.
- Push and pop in the same cycle are both performed; the count is unchanged. oINFLIGHT equals the FIFO count, updated on the next edge.
- Full FIFO (count=P_TAG_DEPTH): oMUL_REQ=0 and all requesters are busy. A pop in that cycle frees a slot for the next cycle only; there is no same-cycle bypass.
- Pointers wrap modulo P_TAG_DEPTH. The count uses P_TAG_DW+1 bits to distinguish full from empty.
- Reset mid-operation: tags are discarded. The environment must reset mul_float together with this block, because late results would otherwise set oERR.

Test Plan:
All directed tests use a mul_float stub with fixed 3-cycle latency and oDATA=A^B, unless stated otherwise.
- Single requester 0: A=0x82200000, B=0x00000001, held one cycle → oMUL_REQ high with oREQ_BUSY[0]=0; 3 cycles later oRSP_VALID=4'b0001 and oRSP_DATA=0x82200001; oINFLIGHT returns 1 to 0.
- All four requesters valid continuously, A=i, B=0x100 → grants occur in order 0,1,2,3,0; responses arrive on oRSP_VALID bits 0,1,2,3 with data 0x100..0x103, in order.
- Hold iMUL_BUSY=1 for 5 cycles with requester 2 granted → oMUL_A stays stable and the pointer does not advance; the operation is accepted on the first cycle iMUL_BUSY=0.
- Stub latency 20, requester 0 always valid → 8 accepts, then oREQ_BUSY[0]=1 and oINFLIGHT=8; the first pop re-enables acceptance on the following cycle.
- Response for requester 1 at head with iRSP_BUSY[1]=1 for 4 cycles → oMUL_BUSY=1 for 4 cycles and the result is held; iDATA_BUSY stalls the stub.
- Force a stub result with the FIFO empty → no oRSP_VALID and oERR=1. Pulse iRESET_SYNC → oERR=0 and oINFLIGHT=0.
